// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. debug unit, with starvation
// forcing and a one-entry skid buffer. Optional stats counters under WB_ARB_STATS_EN.
module wb_port_arbiter #(
   parameter int NB_DATA    = 32,
   parameter int NB_REG     = 5,
   parameter int MAX_STARVE = 4,
   parameter int NB_STARVE  = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_wb_valid,
   input  logic [NB_REG-1:0]  i_wb_reg,
   input  logic [NB_DATA-1:0] i_wb_data,
   input  logic               i_dbg_req,
   input  logic [NB_REG-1:0]  i_dbg_reg,
   input  logic [NB_DATA-1:0] i_dbg_data,
   output logic               o_dbg_ack,
   output logic               o_stall,
   output logic               o_rf_we,
   output logic [NB_REG-1:0]  o_rf_reg,
   output logic [NB_DATA-1:0] o_rf_data
`ifdef WB_ARB_STATS_EN
   ,
   output logic [31:0]        o_stall_cnt,
   output logic [31:0]        o_dbg_cnt
`endif
);

   // state       | meaning
   // IDLE        | debug requests are eligible for arbitration
   // DBG_RELEASE | debug write acked, waiting for i_dbg_req to drop
   typedef enum logic {IDLE, DBG_RELEASE} state_t;

   localparam logic [NB_STARVE-1:0] STARVE_LIMIT = NB_STARVE'(MAX_STARVE);

   state_t               state;
   logic [NB_STARVE-1:0] starve_cnt;
   logic                 skid_valid;
   logic [NB_REG-1:0]    skid_reg;
   logic [NB_DATA-1:0]   skid_data;

   logic dbg_elig;
   logic forced;
   logic dbg_win;

   always_comb begin
      dbg_elig = (state == IDLE) && i_dbg_req;
      forced   = !skid_valid && dbg_elig && (starve_cnt == STARVE_LIMIT);
      dbg_win  = forced || (!skid_valid && !i_wb_valid && dbg_elig);
   end

   assign o_stall = skid_valid;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         skid_valid <= 1'b0;
         skid_reg   <= '0;
         skid_data  <= '0;
         o_dbg_ack  <= 1'b0;
         o_rf_we    <= 1'b0;
         o_rf_reg   <= '0;
         o_rf_data  <= '0;
      end else begin
         o_dbg_ack <= dbg_win;

         // Register 0 still consumes the slot; only the write enable is suppressed.
         if (skid_valid) begin
            o_rf_we    <= |skid_reg;
            o_rf_reg   <= skid_reg;
            o_rf_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (dbg_win) begin
            o_rf_we    <= |i_dbg_reg;
            o_rf_reg   <= i_dbg_reg;
            o_rf_data  <= i_dbg_data;
            skid_valid <= forced && i_wb_valid;
            skid_reg   <= i_wb_reg;
            skid_data  <= i_wb_data;
         end else if (i_wb_valid) begin
            o_rf_we   <= |i_wb_reg;
            o_rf_reg  <= i_wb_reg;
            o_rf_data <= i_wb_data;
         end else begin
            o_rf_we <= 1'b0;
         end

         if (!i_dbg_req || dbg_win)
            starve_cnt <= '0;
         else if (dbg_elig && starve_cnt != STARVE_LIMIT)
            starve_cnt <= starve_cnt + 1'b1;

         case (state)
            IDLE:        if (dbg_win) state <= DBG_RELEASE;
            DBG_RELEASE: if (!i_dbg_req) state <= IDLE;
            default:     state <= IDLE;
         endcase
      end
   end

`ifdef WB_ARB_STATS_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_dbg_cnt   <= '0;
      end else begin
         if (skid_valid) o_stall_cnt <= o_stall_cnt + 32'd1;
         if (dbg_win)    o_dbg_cnt   <= o_dbg_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-based reference model, directed scenarios
// then random traffic. Stats outputs are checked when WB_ARB_STATS_EN is defined.
module tb_wb_port_arbiter;
   localparam int MAX_STARVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        dbg_req = 1'b0;
   logic [4:0]  dbg_reg = '0;
   logic [31:0] dbg_data = '0;
   logic        dbg_ack, stall, rf_we;
   logic [4:0]  rf_reg;
   logic [31:0] rf_data;
`ifdef WB_ARB_STATS_EN
   logic [31:0] stall_cnt, dbg_cnt;
`endif

   always #5 clk = ~clk;

   wb_port_arbiter #(.NB_DATA(32), .NB_REG(5), .MAX_STARVE(MAX_STARVE), .NB_STARVE(4)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_wb_valid(wb_valid), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
      .i_dbg_req(dbg_req), .i_dbg_reg(dbg_reg), .i_dbg_data(dbg_data),
      .o_dbg_ack(dbg_ack), .o_stall(stall),
      .o_rf_we(rf_we), .o_rf_reg(rf_reg), .o_rf_data(rf_data)
`ifdef WB_ARB_STATS_EN
      , .o_stall_cnt(stall_cnt), .o_dbg_cnt(dbg_cnt)
`endif
   );

   typedef struct {logic [4:0] r; logic [31:0] d;} wr_t;
   typedef struct {
      logic we, ack, stall, rst;
      logic [4:0] rg;
      logic [31:0] dt;
      int unsigned sc, dc;
   } exp_t;

   exp_t exp_q[$];
   wr_t  wb_q[$];      // pipeline transactions waiting to be accepted
   wr_t  m_skid[$];    // model skid buffer (0 or 1 entry)

   int unsigned n_cmp = 0, n_bad = 0;

   // reference model state
   bit          m_rel = 0;
   int          m_lost = 0;
   logic        m_we = 0, m_ack = 0;
   logic [4:0]  m_reg = '0;
   logic [31:0] m_data = '0;
   int unsigned m_sc = 0, m_dc = 0;

   // debug-unit behaviour
   bit d_req = 0;
   logic [4:0] d_reg = '0;
   logic [31:0] d_data = '0;
   int d_hold = 0, d_after = -1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp("rf_we", 32'(rf_we), 32'(e.we));
         cmp("dbg_ack", 32'(dbg_ack), 32'(e.ack));
         cmp("stall", 32'(stall), 32'(e.stall));
         if (e.we || e.rst) begin
            cmp("rf_reg", 32'(rf_reg), 32'(e.rg));
            cmp("rf_data", rf_data, e.dt);
         end
`ifdef WB_ARB_STATS_EN
         cmp("stall_cnt", stall_cnt, e.sc);
         cmp("dbg_cnt", dbg_cnt, e.dc);
`endif
      end
   end

   task automatic model_write(input wr_t w);
      m_we = (w.r != 5'd0);
      m_reg = w.r;
      m_data = w.d;
   endtask

   // One clock edge: present inputs, let the model decide, push the expected next cycle.
   task automatic step(input bit do_rst);
      bit elig, win, wbv, stalled;
      wr_t cur, dw;
      exp_t e;
      if (d_after == 0) begin d_req = 0; d_after = -1; end
      else if (d_after > 0) d_after--;
      wbv = (wb_q.size() > 0);
      if (wbv) cur = wb_q[0];
      else begin cur.r = 5'($urandom); cur.d = $urandom; end
      rst = do_rst;
      wb_valid = wbv; wb_reg = cur.r; wb_data = cur.d;
      dbg_req = d_req; dbg_reg = d_reg; dbg_data = d_data;
      @(posedge clk);
      stalled = (m_skid.size() > 0);
      win = 0;
      if (do_rst) begin
         m_skid.delete(); m_rel = 0; m_lost = 0;
         m_we = 0; m_reg = '0; m_data = '0; m_sc = 0; m_dc = 0;
      end else begin
         elig = d_req && !m_rel;
         if (stalled) begin
            model_write(m_skid.pop_front());
            m_sc++;
         end else if (elig && m_lost == MAX_STARVE) begin
            win = 1;
            if (wbv) m_skid.push_back(cur);
         end else if (wbv) model_write(cur);
         else if (elig) win = 1;
         else m_we = 0;
         if (win) begin
            dw.r = d_reg; dw.d = d_data;
            model_write(dw);
            m_dc++;
            m_rel = 1;
            d_after = d_hold;
         end else if (!d_req) m_rel = 0;
         if (!d_req || win) m_lost = 0;
         else if (elig) m_lost = (m_lost < MAX_STARVE) ? m_lost + 1 : MAX_STARVE;
         if (wbv && !stalled) void'(wb_q.pop_front());
      end
      m_ack = win;
      e.we = m_we; e.ack = m_ack; e.stall = (m_skid.size() > 0); e.rst = do_rst;
      e.rg = m_reg; e.dt = m_data; e.sc = m_sc; e.dc = m_dc;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
      wr_t w;
      w.r = r; w.d = d;
      wb_q.push_back(w);
   endtask

   task automatic dbg_start(input logic [4:0] r, input logic [31:0] d, input int hold);
      d_req = 1; d_reg = r; d_data = d; d_hold = hold; d_after = -1;
   endtask

   task automatic drain(input int budget, input string nm);
      int k = 0;
      while ((wb_q.size() > 0 || d_req || m_skid.size() > 0) && k < budget) begin
         step(0);
         k++;
      end
      n_cmp++;
      if (k >= budget) begin
         n_bad++;
         $display("FAIL %s: traffic still pending after %0d cycles", nm, budget);
      end
   endtask

   task automatic starve_burst(input logic [4:0] dr, input logic [31:0] dd);
      for (int i = 0; i < 8; i++) push_wb(5'(i + 10), 32'h5000 + 32'(i));
      dbg_start(dr, dd, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      step(1); step(1);
      step(0);

      push_wb(5'd3, 32'hAAAA); push_wb(5'd4, 32'hBBBB);
      drain(20, "b2b_wb");
      step(0);

      dbg_start(5'd7, 32'h1234, 3);
      drain(20, "dbg_idle");
      step(0);

      starve_burst(5'd9, 32'hD00D);
      drain(40, "starve1");
      step(0);

      push_wb(5'd0, 32'hFFFF);
      drain(10, "wb_r0");
      dbg_start(5'd0, 32'h7777, 1);
      drain(10, "dbg_r0");
      step(0);

      starve_burst(5'd11, 32'hBEEF);
      drain(40, "starve2");
      step(0);

      starve_burst(5'd12, 32'hCAFE);
      k = 0;
      while (m_skid.size() == 0 && k < 20) begin step(0); k++; end
      cmp("reach_stall", 32'(m_skid.size()), 32'd1);
      wb_q.delete(); d_req = 0; d_after = -1;
      step(1);
      step(0);
      dbg_start(5'd13, 32'h600D, 2);
      drain(20, "rereq");

      for (int c = 0; c < 3000; c++) begin
         if (wb_q.size() == 0 && $urandom_range(0, 9) < 7)
            push_wb(5'($urandom_range(0, 31)), $urandom);
         if (!d_req && $urandom_range(0, 7) == 0)
            dbg_start(5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)));
         step(0);
      end
      drain(60, "random_tail");
      step(0); step(0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between the pipeline write-back stage and the debug unit.
- The debug unit writes registers while the CPU runs or is halted.
- Pipeline writes normally win. A starvation counter forces a debug grant. A one-entry skid buffer holds the displaced pipeline write and stalls the pipeline for one cycle.
- All register-file outputs are registered, so register-file timing is unchanged.

Parameters:
- NB_DATA, 32, register data width
- NB_REG, 5, register address width
- MAX_STARVE, 4, consecutive lost arbitration cycles before a debug request is forced through (1..15)
- NB_STARVE, 4, starvation counter width

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_valid  in  1  write-back stage presents a register write this cycle
- i_wb_reg  in  NB_REG  write-back destination register
- i_wb_data  in  NB_DATA  write-back data
- i_dbg_req  in  1  debug write request, level, held until ack
- i_dbg_reg  in  NB_REG  debug destination register, stable while req is high
- i_dbg_data  in  NB_DATA  debug data, stable while req is high
- o_dbg_ack  out  1  one-cycle pulse: the debug write was issued this cycle
- o_stall  out  1  combinational; high while the skid buffer is full; pipeline holds write-back inputs
- o_rf_we  out  1  register-file write enable, registered
- o_rf_reg  out  NB_REG  register-file write address, registered
- o_rf_data  out  NB_DATA  register-file write data, registered

Behaviour:
- Reset (i_clock edge with i_reset=1): o_rf_we=0, o_rf_reg=0, o_rf_data=0, o_dbg_ack=0, skid empty (so o_stall=0), starvation counter=0, FSM=IDLE. A pending skid entry and a pending debug request are dropped without ack. The debug unit must re-request.
- Latency: the winner at edge N appears on o_rf_* (and o_dbg_ack for a debug win) during cycle N+1.
- FSM states: IDLE (debug requests eligible) and DBG_RELEASE (ack given, waiting for i_dbg_req=0).
  - IDLE -> DBG_RELEASE on a debug win.
  - DBG_RELEASE -> IDLE when i_dbg_req=0.
  - In DBG_RELEASE, i_dbg_req is ignored.
- Priority each cycle, highest first:
  1. Skid entry: drain it. i_wb_* is ignored because o_stall=1.
  2. Forced debug: IDLE, i_dbg_req=1, counter==MAX_STARVE. Issue the debug write. If i_wb_valid=1, capture i_wb_reg/i_wb_data into skid.
  3. Pipeline write: i_wb_valid=1.
  4. Debug write: IDLE, i_dbg_req=1.
  5. Otherwise o_rf_we=0 next cycle; o_rf_reg/o_rf_data hold.
- Starvation counter:
  - Increments, saturating at MAX_STARVE, each cycle IDLE with i_dbg_req=1 and debug loses.
  - Clears on a debug win or when i_dbg_req=0.
- Register 0: a pipeline or skid write to register 0 issues with o_rf_we=0, and the slot is still consumed. A debug write to register 0 gets o_dbg_ack=1 with o_rf_we=0.
- Stall sequencing: skid captured at edge N gives o_stall=1 during cycle N+1. The skid drains at edge N+1, and o_stall=0 from cycle N+2. o_stall never lasts more than one cycle per forced grant.
- The skid cannot overflow: forced debug requires IDLE, and the skid drains before the next debug grant can occur.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined adds two outputs:
  - o_stall_cnt (32 bits): increments each cycle o_stall=1.
  - o_dbg_cnt (32 bits): increments each o_dbg_ack pulse.
  - Both are cleared by i_reset, wrap at 2^32, and are readable by the debug unit.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Back-to-back pipeline writes, no debug: i_wb_valid=1 with reg 3/data 0xAAAA then reg 4/data 0xBBBB -> o_rf_we=1 with those values one cycle later each; o_stall stays 0.
- Debug write, pipeline idle: i_dbg_req=1, reg 7, data 0x1234 -> next cycle o_rf_we=1, reg 7, 0x1234, o_dbg_ack=1 for exactly one cycle. Req held high for 3 more cycles -> no further ack.
- Starvation with MAX_STARVE=4: i_wb_valid=1 every cycle plus i_dbg_req=1 -> 4 pipeline writes, then the debug write issues. o_stall=1 for one cycle, the skid write (the 5th pipeline write) issues next, and no pipeline write is lost or duplicated.
- Register 0: pipeline write to reg 0, data 0xFFFF -> o_rf_we stays 0. Debug write to reg 0 -> o_dbg_ack=1, o_rf_we=0.
- Reset mid-stall: assert i_reset in the cycle o_stall=1 -> next cycle o_stall=0, o_rf_we=0, no ack, counter=0. Debug re-request is then granted normally.
- WB_ARB_STATS_EN defined: run the starvation scenario twice -> o_stall_cnt=2, o_dbg_cnt=2. Reset -> both 0.
